// File: rtl/ISO14443A_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ISO14443A_pkg
//  Description : Shared types and constants for the ISO14443A PCD->PICC
//                receive path. Holds the Modified Miller sequence type
//                produced by sequence_decode and the frame-decoder state type.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ISO14443A_pkg;

    // One Modified Miller bit period as classified by sequence_decode.
    typedef enum logic [1:0] {
        PCDBitSequence_ERROR = 2'd0,
        PCDBitSequence_X     = 2'd1,
        PCDBitSequence_Y     = 2'd2,
        PCDBitSequence_Z     = 2'd3
    } PCDBitSequence;

    // Frame decoder FSM state.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } RxFrameState;

    // Eight data bits followed by one odd-parity bit.
    localparam int BITS_PER_GROUP = 9;

endpackage
`default_nettype wire

// File: rtl/rx_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_byte_assembler
//  Description : Packs committed frame bits into bytes, LSB first, and checks
//                the odd parity bit that closes each 9-bit group. A flush
//                emits any partially filled byte without a parity verdict.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                bit_i, bit_valid_i - committed bit and its strobe
//                flush_i           - end of frame: emit partial byte if any
//                clear_i           - drop the current group without output
//                data_o, data_bits_o, parity_error_o, data_valid_o - byte out
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_assembler
    import ISO14443A_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_i,
    input  logic       bit_valid_i,
    input  logic       flush_i,
    input  logic       clear_i,
    output logic [7:0] data_o,
    output logic [3:0] data_bits_o,
    output logic       data_valid_o,
    output logic       parity_error_o
);

    localparam logic [3:0] PARITY_POS = 4'(BITS_PER_GROUP - 1);

    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [3:0] data_bits_q, data_bits_d;
    logic       data_valid_q, data_valid_d;
    logic       parity_error_q, parity_error_d;

    always_comb begin
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        data_d         = data_q;
        data_bits_d    = data_bits_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;

        if (clear_i) begin
            cnt_d   = 4'd0;
            shift_d = 8'd0;
        end else if (flush_i) begin
            // A group cut short (including 8 bits with no parity) is a
            // partial byte and carries no parity verdict.
            if (cnt_q != 4'd0) begin
                data_valid_d   = 1'b1;
                data_d         = shift_q;
                data_bits_d    = cnt_q;
                parity_error_d = 1'b0;
            end
            cnt_d   = 4'd0;
            shift_d = 8'd0;
        end else if (bit_valid_i) begin
            if (cnt_q == PARITY_POS) begin
                // Odd parity: data plus parity must hold an odd number of 1s.
                data_valid_d   = 1'b1;
                data_d         = shift_q;
                data_bits_d    = 4'd8;
                parity_error_d = ~(^shift_q ^ bit_i);
                cnt_d          = 4'd0;
                shift_d        = 8'd0;
            end else begin
                shift_d[cnt_q[2:0]] = bit_i;
                cnt_d               = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= 4'd0;
            shift_q        <= 8'd0;
            data_q         <= 8'd0;
            data_bits_q    <= 4'd0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            data_q         <= data_d;
            data_bits_q    <= data_bits_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign data_o         = data_q;
    assign data_bits_o    = data_bits_q;
    assign data_valid_o   = data_valid_q;
    assign parity_error_o = parity_error_q;

endmodule
`default_nettype wire

// File: rtl/rx_frame_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_decode
//  Description : Frame-level Modified Miller decoder for the PCD->PICC path.
//                Tracks SOC / data / EOC, holds one pending bit so the final
//                logic 0 of EOC is never committed, and hands committed bits
//                to rx_byte_assembler for byte packing and parity checking.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                seq, seq_valid       - sequence from sequence_decode
//                soc, eoc, error      - frame delimiter / abort pulses
//                data, data_bits, data_valid, parity_error - byte stream
//                active               - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_decode
    import ISO14443A_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  PCDBitSequence seq,
    input  logic          seq_valid,
    output logic          soc,
    output logic          eoc,
    output logic          error,
    output logic [7:0]    data,
    output logic [3:0]    data_bits,
    output logic          data_valid,
    output logic          parity_error,
    output logic          active
);

    RxFrameState state_q, state_d;
    logic        prev_bit_q, prev_bit_d;
    logic        pend_v_q, pend_v_d;
    logic        pend_b_q, pend_b_d;
    logic        soc_q, soc_d;
    logic        eoc_q, eoc_d;
    logic        error_q, error_d;

    logic        commit;
    logic        flush;
    logic        clear;

    always_comb begin
        state_d    = state_q;
        prev_bit_d = prev_bit_q;
        pend_v_d   = pend_v_q;
        pend_b_d   = pend_b_q;
        soc_d      = 1'b0;
        eoc_d      = 1'b0;
        error_d    = 1'b0;
        commit     = 1'b0;
        flush      = 1'b0;
        clear      = 1'b0;

        if (seq_valid) begin
            case (state_q)
                IDLE: begin
                    if (seq == PCDBitSequence_Z) begin
                        soc_d      = 1'b1;
                        state_d    = DATA;
                        prev_bit_d = 1'b0;
                        pend_v_d   = 1'b0;
                        pend_b_d   = 1'b0;
                        clear      = 1'b1;
                    end
                end
                DATA: begin
                    // Abort is the fall-through; legal sequences override it.
                    error_d  = 1'b1;
                    state_d  = IDLE;
                    pend_v_d = 1'b0;
                    clear    = 1'b1;
                    case (seq)
                        PCDBitSequence_X: begin
                            error_d    = 1'b0;
                            state_d    = DATA;
                            clear      = 1'b0;
                            commit     = pend_v_q;
                            pend_v_d   = 1'b1;
                            pend_b_d   = 1'b1;
                            prev_bit_d = 1'b1;
                        end
                        PCDBitSequence_Z: begin
                            // Z cannot follow a logic 1: left as abort.
                            if (!prev_bit_q) begin
                                error_d  = 1'b0;
                                state_d  = DATA;
                                clear    = 1'b0;
                                commit   = pend_v_q;
                                pend_v_d = 1'b1;
                                pend_b_d = 1'b0;
                            end
                        end
                        PCDBitSequence_Y: begin
                            if (prev_bit_q) begin
                                error_d    = 1'b0;
                                state_d    = DATA;
                                clear      = 1'b0;
                                commit     = pend_v_q;
                                pend_v_d   = 1'b1;
                                pend_b_d   = 1'b0;
                                prev_bit_d = 1'b0;
                            end else if (pend_v_q) begin
                                // EOC: the pending 0 belongs to the EOC
                                // pattern and is dropped, not committed.
                                error_d = 1'b0;
                                clear   = 1'b0;
                                flush   = 1'b1;
                                eoc_d   = 1'b1;
                            end
                            // Y right after SOC (empty frame) stays abort.
                        end
                        default: ;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_bit_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_bit_q <= prev_bit_d;
            pend_v_q   <= pend_v_d;
            pend_b_q   <= pend_b_d;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            error_q    <= error_d;
        end
    end

    rx_byte_assembler u_byte_assembler (
        .clk            (clk),
        .rst_n          (rst_n),
        .bit_i          (pend_b_q),
        .bit_valid_i    (commit),
        .flush_i        (flush),
        .clear_i        (clear),
        .data_o         (data),
        .data_bits_o    (data_bits),
        .data_valid_o   (data_valid),
        .parity_error_o (parity_error)
    );

    assign soc    = soc_q;
    assign eoc    = eoc_q;
    assign error  = error_q;
    assign active = (state_q == DATA);

endmodule
`default_nettype wire
